// File: rtl/packed_array_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// packed_array_pkg
// Shared types and constants for the packed-array unpacker slice.
//   DEF_NUM_ELEMS / DEF_ELEM_W : default geometry of a packed word
//   elem_t / packed_word_t     : element and packed-word types at the default
//                                geometry (for checkers and wrappers)
//   state_e                    : unpacker FSM state
//   emit_index()               : maps emission position to array index
// ---------------------------------------------------------------------------
package packed_array_pkg;

  localparam int DEF_NUM_ELEMS = 6;
  localparam int DEF_ELEM_W    = 4;

  typedef logic [DEF_ELEM_W-1:0]    elem_t;
  typedef elem_t [DEF_NUM_ELEMS-1:0] packed_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Position 'count' in emission order -> array index of that element.
  function automatic int unsigned emit_index(input int unsigned count,
                                             input int unsigned num_elems,
                                             input bit          msb_first);
    return msb_first ? (num_elems - 1 - count) : count;
  endfunction

endpackage

// File: rtl/packed_array_unpacker_elem_sel.sv
// ---------------------------------------------------------------------------
// packed_elem_sel
// Purely combinational select of one element from a packed word.
//   word : packed word, element k = word[k*ELEM_W +: ELEM_W]
//   idx  : array index to select
//   elem : selected element (zero if idx >= NUM_ELEMS)
// ---------------------------------------------------------------------------
module packed_elem_sel #(
  parameter int NUM_ELEMS = 6,
  parameter int ELEM_W    = 4,
  parameter int IDX_W     = $clog2(NUM_ELEMS)
) (
  input  logic [NUM_ELEMS*ELEM_W-1:0] word,
  input  logic [IDX_W-1:0]            idx,
  output logic [ELEM_W-1:0]           elem
);

  // Explicit mux over legal indices so a non-power-of-2 NUM_ELEMS never
  // slices beyond the word.
  always_comb begin
    elem = '0;
    for (int k = 0; k < NUM_ELEMS; k++) begin
      if (idx == IDX_W'(k)) begin
        elem = word[k*ELEM_W +: ELEM_W];
      end
    end
  end

endmodule

// File: rtl/packed_array_unpacker.sv
// ---------------------------------------------------------------------------
// packed_array_unpacker
// Accepts one packed word [NUM_ELEMS-1:0][ELEM_W-1:0] and streams its
// elements out one per handshake.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input word handshake, in_data sampled on it
//   in_data             : packed word, element k = in_data[k*ELEM_W +: ELEM_W]
//   out_valid/out_ready : output element handshake
//   out_data            : current element
//   out_idx             : array index of the current element
//   out_last            : current element is the final one of the word
//   busy                : a word is held (FSM in SEND)
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Once valid is raised it stays high, with data/idx/last stable, until that
// transfer.
//
// Build option PACKED_ARRAY_UNPACKER_PREFETCH_EN: in_ready also rises during
// the last element handshake so the next word loads with no idle cycle.
// ---------------------------------------------------------------------------
module packed_array_unpacker
  import packed_array_pkg::*;
#(
  parameter int NUM_ELEMS = DEF_NUM_ELEMS,
  parameter int ELEM_W    = DEF_ELEM_W,
  parameter int MSB_FIRST = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_ELEMS*ELEM_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ELEM_W-1:0]             out_data,
  output logic [$clog2(NUM_ELEMS)-1:0]  out_idx,
  output logic                          out_last,
  output logic                          busy
);

  localparam int            IW    = $clog2(NUM_ELEMS);
  localparam int            WW    = NUM_ELEMS * ELEM_W;
  localparam logic [IW-1:0] LAST  = IW'(NUM_ELEMS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   count_q, count_d;
  logic [WW-1:0]   word_q, word_d;

  logic            out_valid_q, out_valid_d;
  logic [ELEM_W-1:0] out_data_q, out_data_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;

  logic            in_ready_c;
  logic            in_hs;
  logic            out_hs;
  logic [IW-1:0]   emit_idx_d;
  logic [ELEM_W-1:0] elem_d;

  assign out_hs = out_valid_q && out_ready;

  // in_ready is held low during reset so nothing is accepted on the reset edge.
`ifdef PACKED_ARRAY_UNPACKER_PREFETCH_EN
  assign in_ready_c = !rst && ((state_q == IDLE) ||
                               (out_valid_q && out_last_q && out_ready));
`else
  assign in_ready_c = !rst && (state_q == IDLE);
`endif

  assign in_hs = in_valid && in_ready_c;

  // Next-state logic for the FSM, element counter and held word.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          word_d  = in_data;
          count_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_hs) begin
          if (count_q == LAST) begin
            // Only reachable with prefetch: reload and keep streaming.
            if (in_hs) begin
              word_d  = in_data;
              count_d = '0;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign emit_idx_d = IW'(emit_index(32'(count_d), NUM_ELEMS, MSB_FIRST != 0));

  packed_elem_sel #(
    .NUM_ELEMS (NUM_ELEMS),
    .ELEM_W    (ELEM_W),
    .IDX_W     (IW)
  ) u_elem_sel (
    .word (word_d),
    .idx  (emit_idx_d),
    .elem (elem_d)
  );

  // Outputs are registered from the next-state values, so they change only
  // when count or word changes and therefore hold across a stall.
  always_comb begin
    out_valid_d = (state_d == SEND);
    out_data_d  = elem_d;
    out_idx_d   = emit_idx_d;
    out_last_d  = (state_d == SEND) && (count_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_packed_array_unpacker.sv
// ---------------------------------------------------------------------------
// tb_packed_array_unpacker
// Two unpackers (LSB-first and MSB-first) share one stimulus stream. A
// reference model turns every accepted word into the expected element
// sequence for each instance; a negedge monitor compares emitted elements,
// valid/busy occupancy and stall stability against it.
// ---------------------------------------------------------------------------
module tb_packed_array_unpacker;

  localparam int N  = 6;
  localparam int EW = 4;
  localparam int IW = 3;
  localparam int W  = N * EW;
  localparam int EXPW = 1 + IW + EW;

`ifdef PACKED_ARRAY_UNPACKER_PREFETCH_EN
  localparam int EXP_B2B = 2 * N;
`else
  localparam int EXP_B2B = 2 * N + 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;

  logic          in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [EW-1:0] out_data_a;
  logic [IW-1:0] out_idx_a;
  logic          in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [EW-1:0] out_data_b;
  logic [IW-1:0] out_idx_b;

  packed_array_unpacker #(.NUM_ELEMS(N), .ELEM_W(EW), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_idx(out_idx_a), .out_last(out_last_a), .busy(busy_a)
  );

  packed_array_unpacker #(.NUM_ELEMS(N), .ELEM_W(EW), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_idx(out_idx_b), .out_last(out_last_b), .busy(busy_b)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EXPW-1:0] exp_a[$];
  logic [EXPW-1:0] exp_b[$];

  logic            stall_prev = 1'b0;
  logic [EXPW-1:0] prev_a, prev_b;

  always @(negedge clk) begin
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
      stall_prev = 1'b0;
    end else begin
      // A word is held exactly while elements of it remain to be emitted.
      check_eq("valid_a", out_valid_a, exp_a.size() != 0);
      check_eq("busy_a",  busy_a,      exp_a.size() != 0);
      check_eq("valid_b", out_valid_b, exp_b.size() != 0);

      if (stall_prev) begin
        check_eq("stall_a", {out_valid_a, out_last_a, out_idx_a, out_data_a}, {1'b1, prev_a});
        check_eq("stall_b", {out_valid_b, out_last_b, out_idx_b, out_data_b}, {1'b1, prev_b});
      end

      if (out_valid_a && out_ready) begin
        if (exp_a.size() != 0)
          check_eq("elem_a", {out_last_a, out_idx_a, out_data_a}, exp_a.pop_front());
        else
          check_eq("spurious_a", 1, 0);
      end
      if (out_valid_b && out_ready) begin
        if (exp_b.size() != 0)
          check_eq("elem_b", {out_last_b, out_idx_b, out_data_b}, exp_b.pop_front());
        else
          check_eq("spurious_b", 1, 0);
      end

      // Reference model: element k of the word is in_data[k*EW +: EW];
      // LSB-first emits k = 0..N-1, MSB-first emits k = N-1..0.
      if (in_valid && in_ready_a) begin
        for (int k = 0; k < N; k++) begin
          logic [EW-1:0] da, db;
          da = in_data[k*EW +: EW];
          db = in_data[(N-1-k)*EW +: EW];
          exp_a.push_back({k == N-1, IW'(k), da});
          exp_b.push_back({k == N-1, IW'(N-1-k), db});
        end
      end

      stall_prev = out_valid_a && !out_ready;
      prev_a     = {out_last_a, out_idx_a, out_data_a};
      prev_b     = {out_last_b, out_idx_b, out_data_b};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] d);
    int   t;
    logic hs;
    t  = 0;
    hs = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      hs = in_ready_a;
      t++;
      if (!hs) begin
        @(posedge clk); #1;
      end
    end while (!hs && t < 100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    check_eq("send_hs", hs, 1'b1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check_eq("drain", exp_a.size() + exp_b.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, lasts, t0, t1;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid",  out_valid_a, 1'b0);
    check_eq("rst_data",   out_data_a,  '0);
    check_eq("rst_idx",    out_idx_a,   '0);
    check_eq("rst_last",   out_last_a,  1'b0);
    check_eq("rst_busy",   busy_a,      1'b0);
    check_eq("rst_ready",  in_ready_a,  1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", in_ready_a, 1'b1);

    // 1) single-hot word, ordering and last flag
    out_ready = 1'b1;
    send_word(24'h000001);
    wait_drain();
    @(negedge clk);
    check_eq("ready_idle", in_ready_a, 1'b1);

    // 2) distinct nibbles, both orders
    send_word(24'h654321);
    wait_drain();

    // 3) stall on element 2
    send_word(24'hABCDEF);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_data_a", out_data_a, 4'hD);
      check_eq("stall_idx_a",  out_idx_a,  3'd2);
      check_eq("stall_data_b", out_data_b, 4'hC);
      check_eq("stall_idx_b",  out_idx_b,  3'd3);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // 4) reset pulse mid-word
    send_word(24'h123456);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("ready_in_rst", in_ready_a, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("valid_after_rst_a", out_valid_a, 1'b0);
    check_eq("valid_after_rst_b", out_valid_b, 1'b0);
    check_eq("ready_after_rst2",  in_ready_a,  1'b1);
    send_word(24'h000001);
    @(negedge clk);
    check_eq("first_after_rst", out_data_a, 4'h1);
    wait_drain();

    // 5) back-to-back words, in_valid and out_ready held high
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 24'h111111;
    acc = 0; lasts = 0; t0 = 0; t1 = 0;
    for (int c = 0; c < 80 && lasts < 2; c++) begin
      @(negedge clk);
      if (in_valid && in_ready_a) begin
        acc++;
        if (acc == 1) t0 = cyc;
      end
      if (out_valid_a && out_last_a) begin
        lasts++;
        if (lasts == 2) t1 = cyc;
      end
      @(posedge clk); #1;
      if (acc == 1) in_data = 24'h222222;
      if (acc >= 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check_eq("b2b_lasts", lasts, 2);
    check_eq("b2b_cycles", t1 - t0, EXP_B2B);
    wait_drain();

    // 6) random traffic, in_data churning every cycle
    for (int c = 0; c < 900; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(3) != 0);
      in_valid  = $urandom_range(1) != 0;
      in_data   = W'($urandom);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/packed_array_unpacker.md
Name: packed_array_unpacker

Overview:
Streaming reader for packed logic arrays of the form [NUM_ELEMS-1:0][ELEM_W-1:0]. This block is the consumer-side counterpart of the blocks that build such words: they pack elements into one wide vector, and this block accepts one whole packed word through a valid/ready handshake, then emits its elements one per handshake. Intended use is in the simple-test regression designs, where it checks packed-array element ordering and slicing through synthesis.

Parameters:
NUM_ELEMS, 6, number of packed elements per word (>=2)
ELEM_W, 4, width of one element in bits
MSB_FIRST, 0, 0 = emit element 0 (bits [ELEM_W-1:0]) first; 1 = emit element NUM_ELEMS-1 first

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  packed word available
in_ready  output  1  block can accept a word
in_data  input  NUM_ELEMS*ELEM_W  packed word; element k = in_data[k*ELEM_W +: ELEM_W]
out_valid  output  1  element valid
out_ready  input  1  downstream accepts element
out_data  output  ELEM_W  current element
out_idx  output  $clog2(NUM_ELEMS)  array index of current element (not emission order)
out_last  output  1  current element is the final one of the word
busy  output  1  a word is held (state SEND)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture in_data into word_q, set count=0, go to SEND.
  - SEND: out_valid=1, in_ready=0 (base build). On out_valid&&out_ready with count<NUM_ELEMS-1, increment count. On a handshake with count==NUM_ELEMS-1, go to IDLE.
- Element select: emitted index = count when MSB_FIRST=0, and NUM_ELEMS-1-count when MSB_FIRST=1. out_idx shows that emitted index. out_last = (count==NUM_ELEMS-1) in SEND.
- Latency: word accepted in cycle N; first element valid in cycle N+1. Base throughput is NUM_ELEMS+1 cycles per word with out_ready held high.
- Stall: out_data, out_idx and out_last hold stable while out_valid&&!out_ready. word_q does not change in SEND.
- in_data is sampled only on the input handshake; changes at any other time are ignored.
- Arithmetic: count width is $clog2(NUM_ELEMS); count never exceeds NUM_ELEMS-1, with no wrap past that value. Non-power-of-2 NUM_ELEMS is legal.
- Reset mid-word: the held word is discarded, state returns to IDLE, and out_valid=0 in the next cycle. No partial element appears after reset.
- No combinational path from in_valid to out_valid. In the base build there is also no path from out_ready to in_ready.

Optional Feature:
PACKED_ARRAY_UNPACKER_PREFETCH_EN
- Defined: in_ready = IDLE || (out_valid && out_last && out_ready), combinational from out_ready. A simultaneous last-element handshake and input handshake loads the new word, resets count to 0 and stays in SEND. Result: zero-bubble throughput of NUM_ELEMS cycles per word.
- Undefined: base behaviour, with one IDLE cycle between words.

Decomposition:
- Package packed_array_pkg holds:
  - localparams DEF_NUM_ELEMS=6 and DEF_ELEM_W=4;
  - typedef elem_t (logic [ELEM_W-1:0]);
  - typedef packed_word_t (elem_t [NUM_ELEMS-1:0]);
  - enum state_e {IDLE, SEND}.
- One natural sub-module: packed_elem_sel, a combinational select of element idx from a packed word. It is reused by test checkers.

Test Plan:
1. Reset, then in_data=24'h000001 with out_ready=1 -> out_data sequence 1,0,0,0,0,0; out_idx 0..5; out_last only on idx 5; in_ready returns to 1 one cycle later.
2. in_data=24'h654321, MSB_FIRST=1 -> out_data sequence 6,5,4,3,2,1; out_idx sequence 5,4,3,2,1,0.
3. in_data=24'hABCDEF, out_ready low for 3 cycles on element 2 -> out_data=4'hD and out_idx=2 held stable for all stall cycles, then the sequence continues to 4'hA.
4. rst pulsed for 1 cycle after the 3rd element of 24'h123456 -> out_valid=0 next cycle; in_ready=1 the cycle after rst drops; next word 24'h000001 emits 1 first.
5. Back-to-back words 24'h111111, 24'h222222 with in_valid and out_ready held high -> 13 cycles without PREFETCH_EN, 12 cycles with PREFETCH_EN (no gap between last 1 and first 2).
6. in_data toggled randomly while busy -> emitted elements match only the word captured at the handshake.
